// File: rtl/vad_pkg.sv
// Shared definitions for the VAD capture path: sample-rate and sizing defaults
// plus the buffer reader's state encoding.
package vad_pkg;

    localparam int SAMPLE_RATE     = 16000;
    localparam int ADDR_W_DEFAULT  = 15;
    localparam int DATA_W_DEFAULT  = 16;
    localparam int PREROLL_DEFAULT = 4800;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        DECIDE,
        HOLD
    } state_t;

endpackage

// File: rtl/vad_buffer_reader.sv
// Read side of the VAD capture ring buffer: rewinds a pre-roll at session start
// and streams stored samples over valid/ready until the writer stops.
module vad_buffer_reader
    import vad_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int DATA_W  = DATA_W_DEFAULT,
    parameter int PREROLL = PREROLL_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] wr_ptr,
    input  logic              wr_en,
    input  logic              recording_active,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overrun,
    output logic              done
);

    localparam logic [ADDR_W-1:0] PREROLL_CAP = ADDR_W'(PREROLL);
    localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] fill;
    logic [ADDR_W-1:0] lag;
    logic              rec_q;

    logic              rise;
    logic              lag_zero;
    logic              lap;
    logic              ptr_load;
    logic              ptr_inc;
    logic              capture;
    logic              last_set;
    logic              last_val;
    logic              done_nxt;

    // Unsigned ADDR_W-bit subtraction gives the ring distance directly.
    assign lag      = wr_ptr - rd_ptr;
    assign lag_zero = (lag == '0);
    assign rise     = recording_active & ~rec_q;
    // Writer is about to overwrite the slot the reader has not yet consumed.
    assign lap      = wr_en & busy & (lag == '1);

    assign rd_addr  = rd_ptr;
    assign m_valid  = (state == HOLD);
    assign busy     = (state != IDLE);

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
        state_nxt = state;
        rd_en     = 1'b0;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        capture   = 1'b0;
        last_set  = 1'b0;
        last_val  = 1'b0;
        done_nxt  = 1'b0;

        case (state)
            IDLE: begin
                if (rise) begin
                    ptr_load  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (lag_zero) begin
                    if (!rec_q) begin
                        done_nxt  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    rd_en     = 1'b1;
                    ptr_inc   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                capture   = 1'b1;
                state_nxt = DECIDE;
            end
            DECIDE: begin
                // The beat is only presented once we know whether more data follows.
                if (!lag_zero) begin
                    last_set  = 1'b1;
                    state_nxt = HOLD;
                end else if (!rec_q) begin
                    last_set  = 1'b1;
                    last_val  = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (m_ready) begin
                    done_nxt  = m_last;
                    state_nxt = m_last ? IDLE : FETCH;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // An overrun abandons the session outright: no read, no done.
        if (lap) begin
            state_nxt = IDLE;
            rd_en     = 1'b0;
            ptr_inc   = 1'b0;
            capture   = 1'b0;
            last_set  = 1'b0;
            done_nxt  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rec_q <= 1'b0;
            fill  <= '0;
        end else begin
            rec_q <= recording_active;
            if (wr_en && (fill != PREROLL_CAP)) begin
                fill <= fill + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
        end else if (ptr_load) begin
            rd_ptr <= wr_ptr - fill;
        end else if (ptr_inc) begin
            rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0;
            m_last <= 1'b0;
        end else begin
            if (capture) begin
                m_data <= rd_data;
            end
            if (last_set) begin
                m_last <= last_val;
            end else if (state_nxt != HOLD) begin
                m_last <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= done_nxt;
            if (lap) begin
                overrun <= 1'b1;
            end else if ((state == IDLE) && rise) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vad_buffer_reader.sv
// Scoreboard bench for vad_buffer_reader with a behavioural writer and ring RAM
// where each stored sample equals its write index.
`timescale 1ns/1ps
module tb_vad_buffer_reader;

    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 16;
    localparam int PREROLL = 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [ADDR_W-1:0] wr_ptr;
    logic              wr_en = 1'b0;
    logic              recording_active = 1'b0;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data = '0;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic              m_last;
    logic              busy;
    logic              overrun;
    logic              done;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    beat_t             exp_q[$];
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] wr_cnt;

    int n_checks  = 0;
    int n_errors  = 0;
    int done_cnt  = 0;
    int busy_cyc  = 0;
    int beats     = 0;

    vad_buffer_reader #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .PREROLL (PREROLL)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_ptr           (wr_ptr),
        .wr_en            (wr_en),
        .recording_active (recording_active),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .m_data           (m_data),
        .m_valid          (m_valid),
        .m_ready          (m_ready),
        .m_last           (m_last),
        .busy             (busy),
        .overrun          (overrun),
        .done             (done)
    );

    always #5 clk = ~clk;

    // Writer: stores its running write index and advances the pointer.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            wr_cnt <= '0;
        end else if (wr_en) begin
            ram[wr_ptr] <= wr_cnt;
            wr_ptr      <= wr_ptr + 1'b1;
            wr_cnt      <= wr_cnt + 1'b1;
        end
    end

    always @(posedge clk) begin
        if (rd_en) rd_data <= ram[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake.
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (done) done_cnt++;
                if (busy) busy_cyc++;
                if (m_valid && m_ready) begin
                    beats++;
                    if (exp_q.size() == 0) begin
                        check("beat_queue", exp_q.size(), 1);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_data", m_data, b.data);
                        check("beat_last", m_last, b.last);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        done_cnt = 0;
        busy_cyc = 0;
        beats    = 0;
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        wr_en            = 1'b0;
        recording_active = 1'b0;
        m_ready          = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        clear_counters();
    endtask

    task automatic write_n(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en = 1'b1;
            tick(1);
        end
        wr_en = 1'b0;
    endtask

    task automatic pulse_rec();
        recording_active = 1'b1;
        tick(1);
        recording_active = 1'b0;
    endtask

    task automatic push_range(input int first, input int last_idx);
        beat_t b;
        for (int i = first; i <= last_idx; i++) begin
            b.data = DATA_W'(i);
            b.last = (i == last_idx);
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_end(input string tag, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) tick(1);
        tick(3);
        check({tag, "_done_once"}, done_cnt, 1);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        for (int i = 0; i < budget && !m_valid; i++) tick(1);
        check({tag, "_valid"}, m_valid, 1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun, 0);
        check({tag, "_done"}, done, 0);
    endtask

    initial begin
        // Pre-roll of 8 over 25 writes: beats 12..24.
        do_reset();
        check_outputs_zero("rst");
        write_n(20);
        push_range(12, 24);
        recording_active = 1'b1;
        write_n(5);
        recording_active = 1'b0;
        wait_end("s1", 400);
        check("s1_beats", beats, 13);

        // Short fill: only 3 samples available to rewind.
        do_reset();
        write_n(3);
        push_range(0, 2);
        pulse_rec();
        wait_end("s2", 200);
        check("s2_beats", beats, 3);

        // Empty session straight out of reset.
        do_reset();
        pulse_rec();
        wait_end("s3", 50);
        check("s3_beats", beats, 0);
        check("s3_busy_cycles", busy_cyc, 2);

        // Backpressure on the first beat for 10 cycles.
        do_reset();
        write_n(16);
        push_range(8, 15);
        m_ready = 1'b0;
        pulse_rec();
        wait_valid("s4", 50);
        for (int i = 0; i < 10; i++) begin
            check("s4_stall_data", m_data, 8);
            check("s4_stall_last", m_last, 0);
            check("s4_stall_valid", m_valid, 1);
            tick(1);
        end
        m_ready = 1'b1;
        wait_end("s4", 300);
        check("s4_beats", beats, 8);

        // Writer laps a stalled reader, then a new session wraps the ring.
        do_reset();
        m_ready          = 1'b0;
        recording_active = 1'b1;
        write_n(70);
        check("s5_overrun", overrun, 1);
        check("s5_valid_dropped", m_valid, 0);
        check("s5_aborted", busy, 0);
        check("s5_no_done", done_cnt, 0);
        check("s5_no_beat", beats, 0);
        recording_active = 1'b0;
        tick(2);
        m_ready = 1'b1;
        push_range(62, 69);
        recording_active = 1'b1;
        tick(1);
        check("s5_overrun_cleared", overrun, 0);
        check("s5_restart_busy", busy, 1);
        recording_active = 1'b0;
        wait_end("s5", 300);
        check("s5_beats", beats, 8);

        // Asynchronous reset while a beat is held.
        do_reset();
        m_ready = 1'b0;
        write_n(12);
        pulse_rec();
        wait_valid("s6", 50);
        check("s6_held_data", m_data, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("s6_rst");
        tick(1);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        tick(1);
        clear_counters();
        write_n(5);
        push_range(0, 4);
        pulse_rec();
        wait_end("s6", 200);
        check("s6_beats", beats, 5);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached with %0d checks", n_checks);
        $fatal(1);
    end

endmodule
